// File: rtl/img_sram_writer.sv
// rtl/img_sram_writer.sv - packs a 24-bit RGB pixel stream into two 16-bit SRAM words per pixel
//
// Purpose:
//   Frame capture side of the SRAM image buffer. Pixel k = x + y*WIDTH is
//   stored at word address {k,0} = {8'h00,R} and {k,1} = {G,B}. A frame is
//   armed by i_start, begins at the first pixel flagged with i_sof, and ends
//   with a one-cycle o_frame_done pulse after the last word is written.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous reset, active-high
//   i_start       one-cycle pulse, arms capture of one frame (ignored while busy)
//   i_valid       pixel valid
//   i_sof         qualifies i_valid: pixel is the first of a frame
//   i_pixel       {R[23:16], G[15:8], B[7:0]}
//   o_ready       writer accepts a pixel this cycle (depends on state only)
//   o_sram_addr   SRAM word address (registered)
//   o_sram_data   SRAM write data (registered)
//   o_sram_we_n   SRAM write enable, active-low (registered)
//   o_busy        high in every state except IDLE
//   o_frame_done  one-cycle pulse after the last word of a frame
module img_sram_writer #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [23:0]       i_pixel,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_data,
    output logic              o_sram_we_n,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SOF = 3'd1,
        S_WORD0    = 3'd2,
        S_WORD1    = 3'd3,
        S_ACCEPT   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       gb_q, gb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              we_n_q, we_n_d;
    logic              xfer;

    assign xfer = i_valid && o_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (i_start) state_d = S_WAIT_SOF;
            S_WAIT_SOF: if (xfer && i_sof) state_d = S_WORD0;
            S_WORD0:    state_d = S_WORD1;
            S_WORD1: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else if (xfer) begin
                    state_d = S_WORD0;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT:   if (xfer) state_d = S_WORD0;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state only, so o_ready never depends on i_valid
    always_comb begin
        o_ready      = 1'b0;
        o_busy       = (state_q != S_IDLE);
        o_frame_done = (state_q == S_DONE);
        case (state_q)
            S_WAIT_SOF: o_ready = 1'b1;
            S_WORD1:    o_ready = (idx_q != LAST_IDX);
            S_ACCEPT:   o_ready = 1'b1;
            default:    o_ready = 1'b0;
        endcase
    end

    // SRAM port is registered: its next value is derived from the state being
    // entered, so the word0 write appears in the cycle after the transfer edge.
    always_comb begin
        idx_d  = idx_q;
        gb_d   = gb_q;
        addr_d = addr_q;
        data_d = data_q;
        we_n_d = 1'b1;
        if (state_d == S_WORD0) begin
            // WORD0 is only ever entered on an accepted pixel; i_sof resyncs
            // the frame to pixel 0 (always the case coming from WAIT_SOF).
            idx_d  = i_sof ? '0 : idx_q + IDX_W'(1);
            gb_d   = i_pixel[15:0];
            addr_d = {idx_d, 1'b0};
            data_d = {8'h00, i_pixel[23:16]};
            we_n_d = 1'b0;
        end else if (state_d == S_WORD1) begin
            addr_d = {idx_q, 1'b1};
            data_d = gb_q;
            we_n_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q  <= '0;
            gb_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_n_q <= 1'b1;
        end else begin
            idx_q  <= idx_d;
            gb_q   <= gb_d;
            addr_q <= addr_d;
            data_q <= data_d;
            we_n_q <= we_n_d;
        end
    end

    assign o_sram_addr = addr_q;
    assign o_sram_data = data_q;
    assign o_sram_we_n = we_n_q;

endmodule

// File: tb/tb_img_sram_writer.sv
// tb/tb_img_sram_writer.sv - self-checking bench for img_sram_writer (4x2 frame)
module tb_img_sram_writer;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int ADDR_W = 20;

    logic              clk;
    logic              rst;
    logic              start;
    logic              valid;
    logic              sof;
    logic [23:0]       pixel;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_data;
    logic              sram_we_n;
    logic              busy;
    logic              frame_done;

    img_sram_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_valid      (valid),
        .i_sof        (sof),
        .i_pixel      (pixel),
        .o_ready      (ready),
        .o_sram_addr  (sram_addr),
        .o_sram_data  (sram_data),
        .o_sram_we_n  (sram_we_n),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic        sof;
        logic [23:0] pixel;
        logic        rdy;
        logic        bsy;
        logic        done;
        logic        wen;
        logic        acc;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    int  exp_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic st, input logic v, input logic s, input logic [23:0] p,
                                input logic rdy, input logic bsy, input logic done,
                                input logic wen, input logic acc);
        vec_t r;
        r.start = st; r.valid = v; r.sof = s; r.pixel = p;
        r.rdy = rdy; r.bsy = bsy; r.done = done; r.wen = wen; r.acc = acc;
        return r;
    endfunction

    // Accepted pixel: scoreboard gets both words at the bench's own index.
    task automatic push_pixel(input logic s, input logic [23:0] p);
        wr_t w;
        exp_idx = s ? 0 : exp_idx + 1;
        w.addr = ADDR_W'(exp_idx * 2);     w.data = {8'h00, p[23:16]}; exp_q.push_back(w);
        w.addr = ADDR_W'(exp_idx * 2 + 1); w.data = p[15:0];           exp_q.push_back(w);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        start = v.start; valid = v.valid; sof = v.sof; pixel = v.pixel;
        #1;
        chk("ready", ready, v.rdy);
        chk("busy", busy, v.bsy);
        chk("frame_done", frame_done, v.done);
        chk("we_n", sram_we_n, v.wen);
        if (v.acc) push_pixel(v.sof, v.pixel);
    endtask

    // Write monitor: every active write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && sram_we_n == 1'b0) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", sram_addr, sram_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(sram_addr), 32'(w.addr));
                chk("wr_data", 32'(sram_data), 32'(w.data));
            end
        end
    end

    vec_t tbl[24];

    initial begin
        // start valid sof pixel        rdy bsy done wen acc
        tbl[0]  = mk(1, 0, 0, 24'h000000, 0, 0, 0, 1, 0);  // IDLE, arm
        tbl[1]  = mk(0, 1, 0, 24'hAAAAAA, 1, 1, 0, 1, 0);  // WAIT_SOF, non-sof dropped
        tbl[2]  = mk(0, 1, 1, 24'h123456, 1, 1, 0, 1, 1);  // sof accepted
        tbl[3]  = mk(0, 0, 0, 24'h000000, 0, 1, 0, 0, 0);  // WORD0
        tbl[4]  = mk(0, 0, 0, 24'h000000, 1, 1, 0, 0, 0);  // WORD1, no transfer
        tbl[5]  = mk(0, 1, 0, 24'h010203, 1, 1, 0, 1, 1);  // ACCEPT, we_n high
        tbl[6]  = mk(0, 1, 0, 24'h040506, 0, 1, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 24'h040506, 1, 1, 0, 0, 1);
        tbl[8]  = mk(0, 1, 0, 24'h070809, 0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 24'h070809, 1, 1, 0, 0, 1);
        tbl[10] = mk(0, 1, 0, 24'h0A0B0C, 0, 1, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 24'h0A0B0C, 1, 1, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 24'h0D0E0F, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 24'h0D0E0F, 1, 1, 0, 0, 1);
        tbl[14] = mk(0, 1, 0, 24'h101112, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 24'h101112, 1, 1, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 24'h131415, 0, 1, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 24'h131415, 1, 1, 0, 0, 1);  // last pixel (idx 7)
        tbl[18] = mk(1, 1, 0, 24'hFFFFFF, 0, 1, 0, 0, 0);  // start while busy ignored
        tbl[19] = mk(0, 1, 0, 24'hFFFFFF, 0, 1, 0, 0, 0);  // WORD1 of last pixel, not ready
        tbl[20] = mk(0, 1, 0, 24'hFFFFFF, 0, 1, 1, 1, 0);  // DONE pulse
        tbl[21] = mk(0, 1, 1, 24'hFFFFFF, 0, 0, 0, 1, 0);  // IDLE, valid ignored
        tbl[22] = mk(1, 1, 1, 24'hEEEEEE, 0, 0, 0, 1, 0);  // start+valid: arm only
        tbl[23] = mk(0, 0, 0, 24'h000000, 1, 1, 0, 1, 0);  // WAIT_SOF

        start = 0; valid = 0; sof = 0; pixel = '0;
        rst = 1'b1;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom); valid = 1'($urandom); sof = 1'($urandom); pixel = 24'($urandom);
            #1;
            chk("rst_we_n", sram_we_n, 1'b1);
            chk("rst_ready", ready, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", frame_done, 1'b0);
            chk("rst_addr", 32'(sram_addr), 32'h0);
            chk("rst_data", 32'(sram_data), 32'h0);
        end
        @(negedge clk);
        start = 0; valid = 0; sof = 0; pixel = '0;
        rst = 1'b0;

        // Full frame, throughput, boundary, start-while-busy
        for (int i = 0; i < 24; i++) apply(tbl[i]);

        // Drops in WAIT_SOF, mid-frame resync at pixel 5, frame completes after 8 more
        apply(mk(0, 1, 0, 24'h515151, 1, 1, 0, 1, 0));
        apply(mk(0, 1, 0, 24'h525252, 1, 1, 0, 1, 0));
        apply(mk(0, 1, 1, 24'h200000, 1, 1, 0, 1, 1));
        for (int k = 1; k < 5; k++) begin
            apply(mk(0, 1, 0, 24'h200000 + 24'(k * 24'h010101), 0, 1, 0, 0, 0));
            apply(mk(0, 1, 0, 24'h200000 + 24'(k * 24'h010101), 1, 1, 0, 0, 1));
        end
        apply(mk(0, 1, 1, 24'h3C5A7E, 0, 1, 0, 0, 0));
        apply(mk(0, 1, 1, 24'h3C5A7E, 1, 1, 0, 0, 1));      // resync -> idx 0
        for (int k = 1; k < 8; k++) begin
            apply(mk(0, 1, 0, 24'h400000 + 24'(k * 24'h000911), 0, 1, 0, 0, 0));
            apply(mk(0, 1, 0, 24'h400000 + 24'(k * 24'h000911), 1, 1, 0, 0, 1));
        end
        apply(mk(0, 1, 0, 24'h999999, 0, 1, 0, 0, 0));     // WORD0 idx 7
        apply(mk(0, 1, 0, 24'h999999, 0, 1, 0, 0, 0));     // WORD1 idx 7
        apply(mk(0, 1, 0, 24'h999999, 0, 1, 1, 1, 0));     // DONE
        apply(mk(0, 0, 0, 24'h000000, 0, 0, 0, 1, 0));     // IDLE

        // Reset pulsed during WORD0
        apply(mk(1, 0, 0, 24'h000000, 0, 0, 0, 1, 0));
        apply(mk(0, 1, 1, 24'hABCDEF, 1, 1, 0, 1, 0));
        begin
            wr_t w;
            w.addr = '0; w.data = 16'h00AB;
            exp_q.push_back(w);                              // only word0 gets out
        end
        @(negedge clk);
        valid = 0; sof = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_we_n", sram_we_n, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply(mk(0, 1, 1, 24'h777777, 0, 0, 0, 1, 0));
        apply(mk(1, 0, 0, 24'h000000, 0, 0, 0, 1, 0));
        apply(mk(0, 1, 1, 24'hC0FFEE, 1, 1, 0, 1, 1));
        apply(mk(0, 0, 0, 24'h000000, 0, 1, 0, 0, 0));
        apply(mk(0, 0, 0, 24'h000000, 1, 1, 0, 0, 0));
        apply(mk(0, 0, 0, 24'h000000, 1, 1, 0, 1, 0));     // ACCEPT

        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
